// File: rtl/div_seq_32_if.sv
// Request/response bundle between the core and the sequential divider.
// The core drives the operation; the divider returns busy/done/result.
interface div_seq_32_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             flush;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, flush, op, a, b,
    input  busy, done, result
  );

  modport slave (
    input  start, flush, op, a, b,
    output busy, done, result
  );
endinterface

// File: rtl/div_seq_32.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and overflow finish on accept.
module div_seq_32 #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  div_seq_32_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES = '1;

  logic [1:0]       state;
  logic [1:0]       op_q;
  logic             q_neg;
  logic             r_neg;
  logic [WIDTH-1:0] b_mag_q;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] result_q;

  logic             is_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             b_zero;
  logic             ovf;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             fits;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] res_fin;

  assign is_signed = ~bus.op[0];
  assign a_neg     = is_signed & bus.a[WIDTH-1];
  assign b_neg     = is_signed & bus.b[WIDTH-1];
  assign a_mag     = a_neg ? -bus.a : bus.a;
  assign b_mag     = b_neg ? -bus.b : bus.b;
  assign b_zero    = (bus.b == '0);
  assign ovf       = is_signed & (bus.a == MIN) & (bus.b == ONES);

  // Borrow out of the WIDTH+1 bit subtract means the divisor did not fit.
  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, b_mag_q};
  assign fits    = ~diff[WIDTH];
  assign rem_nx  = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_nx  = {quo[WIDTH-2:0], fits};
  assign res_fin = op_q[1] ? (r_neg ? -rem_nx : rem_nx)
                           : (q_neg ? -quo_nx : quo_nx);

  assign bus.busy   = (state == CALC);
  assign bus.done   = (state == DONE);
  assign bus.result = result_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      op_q     <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      b_mag_q  <= '0;
      rem      <= '0;
      quo      <= '0;
      cnt      <= '0;
      result_q <= '0;
    end else if (bus.flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            op_q    <= bus.op;
            q_neg   <= a_neg ^ b_neg;
            r_neg   <= a_neg;
            b_mag_q <= b_mag;
            rem     <= '0;
            quo     <= a_mag;
            cnt     <= CW'(WIDTH - 1);
            if (b_zero) begin
              result_q <= bus.op[1] ? bus.a : ONES;
              state    <= DONE;
            end else if (ovf) begin
              result_q <= bus.op[1] ? '0 : MIN;
              state    <= DONE;
            end else begin
              state <= CALC;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            result_q <= res_fin;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
